riscv_div_seq: RTL

RISCV_DIV_SEQ -- requirements
Module: riscv_div_seq

---
 rtl/riscv_div_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/riscv_div_seq.sv
// Sequential restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_TERM_EN skips the dividend's leading zeros before iterating.
module riscv_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [6:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    input  logic             ex_ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [6:0] ALU_DIVU = 7'b0110000;
    localparam logic [6:0] ALU_DIV  = 7'b0110001;
    localparam logic [6:0] ALU_REMU = 7'b0110010;
    localparam logic [6:0] ALU_REM  = 7'b0110011;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_rem_q, op_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             ready_q, valid_q;
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_div_op, op_signed, b_zero, overflow;
    logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
    logic [WIDTH:0]   trial;

    // Request decode and operand magnitude
    assign is_div_op = (operator_i == ALU_DIVU) || (operator_i == ALU_DIV) ||
                       (operator_i == ALU_REMU) || (operator_i == ALU_REM);
    assign op_signed = operator_i[0];
    assign b_zero    = (op_b_i == '0);
    assign overflow  = op_signed && (op_a_i == MOST_NEG) && (op_b_i == '1);
    assign abs_a     = (op_signed && op_a_i[WIDTH-1]) ? ('0 - op_a_i) : op_a_i;
    assign abs_b     = (op_signed && op_b_i[WIDTH-1]) ? ('0 - op_b_i) : op_b_i;

    // Partial remainder shifted left by one with the next dividend bit, minus divisor
    assign trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, divisor_q};

`ifdef DIV_EARLY_TERM_EN
    localparam int unsigned LZ_W = $clog2(WIDTH + 1);

    function automatic logic [LZ_W-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + LZ_W'(1);
        end
        return n;
    endfunction

    logic [LZ_W-1:0] lead_zeros;
    assign lead_zeros = count_lz(abs_a);
`endif

    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        op_rem_d  = op_rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;

        unique case (state_q)
            IDLE: begin
                if (enable_i && !kill_i && is_div_op) begin
                    divisor_d = abs_b;
                    op_rem_d  = operator_i[1];
                    q_neg_d   = op_signed & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]) & ~b_zero;
                    r_neg_d   = op_signed & op_a_i[WIDTH-1];
                    cnt_d     = CNT_W'(WIDTH - 1);
                    // Special cases preload quotient/remainder so FINISH applies the usual sign fix
                    if (b_zero) begin
                        quot_d  = '1;
                        rem_d   = abs_a;
                        state_d = FINISH;
                    end else if (overflow) begin
                        quot_d  = MOST_NEG;
                        rem_d   = '0;
                        state_d = FINISH;
                    end else begin
                        quot_d  = abs_a;
                        rem_d   = '0;
                        state_d = DIVIDE;
`ifdef DIV_EARLY_TERM_EN
                        if (abs_a == '0) begin
                            state_d = FINISH;
                        end else begin
                            quot_d = abs_a << lead_zeros;
                            cnt_d  = CNT_W'(WIDTH - 1) - CNT_W'(lead_zeros);
                        end
`endif
                    end
                end
            end
            DIVIDE: begin
                if (!trial[WIDTH]) begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = FINISH;
            end
            FINISH: begin
                if (ex_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (kill_i) state_d = IDLE;
    end

    // Result is built from next-state values so it lands in the same edge as valid_o
    assign q_fix    = q_neg_d ? ('0 - quot_d) : quot_d;
    assign r_fix    = r_neg_d ? ('0 - rem_d) : rem_d;
    assign result_d = (state_d == FINISH) ? (op_rem_d ? r_fix : q_fix) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            op_rem_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            op_rem_q  <= op_rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            ready_q   <= (state_d == IDLE);
            valid_q   <= (state_d == FINISH);
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule
